s2p_capture: RTL and testbench

Serial-to-parallel capture block: the receiving end of the segment serial link driven by the display's parallel-to-serial shifter (sclk / sout / EN / sclrn). It oversamples the link with the system clock, shifts in one word per frame and presents the reconstructed `DATA_BITS`-wide word with a one-cycle valid strobe. It sits on the board-test and loopback path, where it checks that the display driver emits exactly the segment pattern it was given.

---
 rtl/s2p_pkg.sv | 19 +
 rtl/sync_edge.sv | 34 +++
 rtl/s2p_capture.sv | 146 ++++++++++++++
 tb/tb_s2p_capture.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/s2p_pkg.sv
// Shared types and defaults for the segment-link serial-to-parallel capture.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package s2p_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam int DEF_DATA_BITS       = 64;
  localparam int DEF_DATA_COUNT_BITS = 6;

  // Wire bit order: where the first received bit ends up in the word.
  localparam bit MSB_FIRST = 1'b1;
  localparam bit LSB_FIRST = 1'b0;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one async input with level, rise and fall outputs.
// Latency: level is SYNC_STAGES cycles behind the pin; edges are flagged in that same cycle.
// Backpressure: none; samples every cycle.
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sreg;
  logic                   prev;

  // Shift the pin through the synchronizer and keep the previous synchronized level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= {SYNC_STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sreg <= {sreg[SYNC_STAGES-2:0], d};
      prev <= sreg[SYNC_STAGES-1];
    end
  end

  assign level = sreg[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/s2p_capture.sv
// Oversampling capture of the segment serial link; rebuilds one DATA_BITS word per EN frame.
// Latency: valid/frame_err strobe SYNC_STAGES+2 cycles after the EN rising pin edge.
// Backpressure: none; the link cannot be stalled, words are presented as one-cycle strobes.
module s2p_capture
  import s2p_pkg::*;
#(
  parameter int DATA_BITS       = DEF_DATA_BITS,
  parameter int DATA_COUNT_BITS = DEF_DATA_COUNT_BITS,
  parameter bit DIR             = MSB_FIRST,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sclk,
  input  logic                     sin,
  input  logic                     EN,
  input  logic                     sclrn,
  output logic [DATA_BITS-1:0]     PData,
  output logic                     valid,
  output logic                     frame_err,
  output logic                     busy,
  output logic [DATA_COUNT_BITS:0] bit_cnt
);

  localparam int CW = DATA_COUNT_BITS + 1;
  localparam logic [CW-1:0] FULL = CW'(DATA_BITS);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic sin_lvl, sin_rise, sin_fall;
  logic en_lvl, en_rise, en_fall;
  logic sclrn_lvl, sclrn_rise, sclrn_fall;

  // Idle levels: sclk, EN and sclrn sit high, so their synchronizers reset high
  // to avoid a spurious edge right after reset.
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );
  // Same depth as sclk so the data bit stays aligned with its clock edge.
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sin (
    .clk(clk), .rst(rst), .d(sin), .level(sin_lvl), .rise(sin_rise), .fall(sin_fall)
  );
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_en (
    .clk(clk), .rst(rst), .d(EN), .level(en_lvl), .rise(en_rise), .fall(en_fall)
  );
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclrn (
    .clk(clk), .rst(rst), .d(sclrn), .level(sclrn_lvl), .rise(sclrn_rise), .fall(sclrn_fall)
  );

  // Only edges of sclk/EN and the levels of sin/sclrn/EN-independent paths are used.
  logic unused_edges;
  assign unused_edges = ^{sclk_lvl, sclk_fall, sin_rise, sin_fall, en_lvl, sclrn_rise, sclrn_fall};

  state_t                 state_q, state_d;
  logic [DATA_BITS-1:0]   sh_q, sh_d;
  logic [CW-1:0]          cnt_d;
  logic                   ovr_q, ovr_d;
  logic                   valid_d, err_d, load_d;

  // Next-state, shift/count and strobe decisions; sclrn overrides everything.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = bit_cnt;
    ovr_d   = ovr_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    load_d  = 1'b0;
    if (!sclrn_lvl) begin
      state_d = IDLE;
      sh_d    = '0;
      cnt_d   = '0;
      ovr_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en_fall) begin
            state_d = SHIFT;
            sh_d    = '0;
            cnt_d   = '0;
            ovr_d   = 1'b0;
          end
        end
        SHIFT: begin
          // A frame-closing EN edge swallows an sclk edge seen in the same cycle.
          if (en_rise) begin
            state_d = LATCH;
          end else if (sclk_rise) begin
            if (bit_cnt == FULL) begin
              ovr_d = 1'b1;
            end else begin
              if (DIR) begin
                sh_d = {sh_q[DATA_BITS-2:0], sin_lvl};
              end else begin
                sh_d = {sin_lvl, sh_q[DATA_BITS-1:1]};
              end
              cnt_d = bit_cnt + 1'b1;
            end
          end
        end
        LATCH: begin
          state_d = IDLE;
          if (bit_cnt == FULL && !ovr_q) begin
            valid_d = 1'b1;
            load_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Frame state, shift register, bit counter and sticky overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bit_cnt <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_cnt <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  // Registered strobes and the captured word, updated together on a good frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PData     <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= valid_d;
      frame_err <= err_d;
      if (load_d) begin
        PData <= sh_q;
      end
    end
  end

  assign busy = (state_q == SHIFT);

endmodule

// File: tb/tb_s2p_capture.sv
module tb_s2p_capture;

  localparam int W = 64;
  localparam int K_EN_FALL = 0, K_EN_RISE = 1, K_SCLK = 2, K_CLR_ON = 3, K_CLR_OFF = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk = 1'b1, sin = 1'b0, EN = 1'b1, sclrn = 1'b1;

  logic [W-1:0] pd1, pd0;
  logic         v1, v0, e1, e0, b1, b0;
  logic [6:0]   c1, c0;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  s2p_capture #(.DATA_BITS(64), .DATA_COUNT_BITS(6), .DIR(1'b1), .SYNC_STAGES(2)) u_msb (
    .clk(clk), .rst(rst), .sclk(sclk), .sin(sin), .EN(EN), .sclrn(sclrn),
    .PData(pd1), .valid(v1), .frame_err(e1), .busy(b1), .bit_cnt(c1)
  );
  s2p_capture #(.DATA_BITS(64), .DATA_COUNT_BITS(6), .DIR(1'b0), .SYNC_STAGES(2)) u_lsb (
    .clk(clk), .rst(rst), .sclk(sclk), .sin(sin), .EN(EN), .sclrn(sclrn),
    .PData(pd0), .valid(v0), .frame_err(e0), .busy(b0), .bit_cnt(c0)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pin-level events; each takes effect on the outputs 3 cycles after the pin moves
  // (two synchronizer flops, then the state update).
  typedef struct {
    int eff;
    int kind;
    bit b;
  } ev_t;
  ev_t evq[$];

  task automatic push(input int kind, input bit b);
    ev_t e;
    e.eff = cyc + 3;
    e.kind = kind;
    e.b = b;
    evq.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_en(input logic v);
    if (v !== EN) push(v ? K_EN_RISE : K_EN_FALL, 1'b0);
    EN = v;
  endtask

  task automatic set_sclk(input logic v);
    if (v === 1'b1 && sclk === 1'b0) push(K_SCLK, sin);
    sclk = v;
  endtask

  task automatic set_sclrn(input logic v);
    if (v !== sclrn) push(v ? K_CLR_OFF : K_CLR_ON, 1'b0);
    sclrn = v;
  endtask

  // Frame-level model: open frame, received bits, overrun, last good words.
  bit           m_open, m_ovr, m_clr;
  int           m_n;
  bit           m_bits[$];
  logic [W-1:0] exp_pd1, exp_pd0, pend1, pend0;
  int           strobe_cyc;
  bit           strobe_good;
  bit           f_fall, f_rise, f_sclk, f_b, x_v, x_e;
  ev_t          ce;

  initial begin
    m_open = 0; m_ovr = 0; m_clr = 0; m_n = 0;
    exp_pd1 = '0; exp_pd0 = '0; strobe_cyc = -1; strobe_good = 0;
  end

  always @(negedge clk) begin
    if (rst) begin
      evq.delete();
      m_bits.delete();
      m_open = 0; m_ovr = 0; m_clr = 0; m_n = 0;
      exp_pd1 = '0; exp_pd0 = '0; strobe_cyc = -1;
      check("rst_pdata_msb", pd1, 64'd0);
      check("rst_pdata_lsb", pd0, 64'd0);
      check("rst_flags", {v1, e1, b1, v0, e0, b0}, 64'd0);
      check("rst_bitcnt", {c1, c0}, 64'd0);
    end else begin
      f_fall = 0; f_rise = 0; f_sclk = 0; f_b = 0;
      while (evq.size() > 0 && evq[0].eff <= cyc) begin
        ce = evq.pop_front();
        case (ce.kind)
          K_EN_FALL: f_fall = 1;
          K_EN_RISE: f_rise = 1;
          K_SCLK:    begin f_sclk = 1; f_b = ce.b; end
          K_CLR_ON:  m_clr = 1;
          default:   m_clr = 0;
        endcase
      end
      if (m_clr) begin
        m_open = 0; m_n = 0; m_ovr = 0;
        m_bits.delete();
        if (strobe_cyc == cyc) strobe_cyc = -1;
      end else if (f_fall && !m_open) begin
        m_open = 1; m_n = 0; m_ovr = 0;
        m_bits.delete();
      end else if (f_rise && m_open) begin
        m_open = 0;
        strobe_cyc = cyc + 1;
        strobe_good = (m_n == W) && !m_ovr;
        pend1 = '0; pend0 = '0;
        for (int i = 0; i < m_bits.size() && i < W; i++) begin
          pend1[W-1-i] = m_bits[i];
          pend0[i] = m_bits[i];
        end
      end else if (f_sclk && m_open) begin
        if (m_n == W) m_ovr = 1;
        else begin m_bits.push_back(f_b); m_n++; end
      end
      x_v = (strobe_cyc == cyc) && strobe_good;
      x_e = (strobe_cyc == cyc) && !strobe_good;
      if (x_v) begin exp_pd1 = pend1; exp_pd0 = pend0; end
      check("valid_msb", v1, x_v);
      check("valid_lsb", v0, x_v);
      check("ferr_msb", e1, x_e);
      check("ferr_lsb", e0, x_e);
      check("busy_msb", b1, m_open);
      check("busy_lsb", b0, m_open);
      check("bitcnt_msb", c1, m_n);
      check("bitcnt_lsb", c0, m_n);
      check("pdata_msb", pd1, exp_pd1);
      check("pdata_lsb", pd0, exp_pd0);
    end
  end

  // One frame on the link; reports strobe latency from the EN rising pin edge.
  task automatic frame(input logic [63:0] w, input int nb, input bit msb, input bit aligned,
                       output int lat, output logic [6:0] cnt_end,
                       output bit sv1, output bit se1, output bit sv0, output bit se0);
    int t0;
    set_en(1'b0);
    tick(4);
    for (int i = 0; i < nb; i++) begin
      int k;
      bit b;
      k = i % 64;
      b = msb ? w[63-k] : w[k];
      set_sclk(1'b0);
      sin = b;
      tick(4);
      if (aligned && i == nb - 1) begin
        set_sclk(1'b1);
        set_en(1'b1);
      end else begin
        set_sclk(1'b1);
        tick(4);
      end
    end
    cnt_end = c1;
    if (!aligned) set_en(1'b1);
    t0 = cyc;
    lat = -1; sv1 = 0; se1 = 0; sv0 = 0; se0 = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (v1 | e1 | v0 | e0) begin
        lat = cyc - t0;
        sv1 = v1; se1 = e1; sv0 = v0; se0 = e0;
        break;
      end
    end
    tick(4);
  endtask

  int         lat;
  logic [6:0] ce_cnt;
  bit         sv1, se1, sv0, se0;

  initial begin
    tick(3);
    rst = 1'b0;
    tick(4);
    check("reset_pdata_lit", pd1, 64'd0);
    check("reset_busy_lit", b1, 1'b0);

    // MSB-first frame into both instances.
    frame(64'hDEADBEEF_01234567, 64, 1'b1, 1'b0, lat, ce_cnt, sv1, se1, sv0, se0);
    check("f1_latency", lat, 4);
    check("f1_valid", {sv1, se1}, 2'b10);
    check("f1_pdata_lit", pd1, 64'hDEADBEEF_01234567);

    // LSB-first frame; the DIR=0 instance reconstructs the word.
    frame(64'hDEADBEEF_01234567, 64, 1'b0, 1'b0, lat, ce_cnt, sv1, se1, sv0, se0);
    check("f2_latency", lat, 4);
    check("f2_valid_lsb", {sv0, se0}, 2'b10);
    check("f2_pdata_lit", pd0, 64'hDEADBEEF_01234567);

    // Short frame.
    frame(64'hFFFF0000_A5A5A5A5, 63, 1'b1, 1'b0, lat, ce_cnt, sv1, se1, sv0, se0);
    check("short_cnt_lit", ce_cnt, 7'd63);
    check("short_ferr", {sv1, se1}, 2'b01);
    check("short_hold_lit", pd0, 64'hDEADBEEF_01234567);

    // Overlong frame.
    frame(64'h13579BDF_2468ACE0, 65, 1'b1, 1'b0, lat, ce_cnt, sv1, se1, sv0, se0);
    check("long_cnt_sat_lit", ce_cnt, 7'd64);
    check("long_ferr", {sv1, se1}, 2'b01);
    check("long_hold_lit", pd0, 64'hDEADBEEF_01234567);

    // sclrn pulse mid-frame: frame dropped silently.
    set_en(1'b0);
    tick(4);
    for (int i = 0; i < 30; i++) begin
      set_sclk(1'b0); sin = i[0]; tick(4);
      set_sclk(1'b1); tick(4);
    end
    set_sclrn(1'b0);
    tick(6);
    set_sclrn(1'b1);
    tick(4);
    set_en(1'b1);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (v1 | e1 | v0 | e0) lat++;
    end
    check("clr_no_strobe", lat, 0);
    check("clr_cnt_lit", c1, 7'd0);
    check("clr_idle_lit", b1, 1'b0);
    tick(4);

    // EN rise coincides with the 64th sclk rise: that bit is dropped.
    frame(64'hCAFEF00D_87654321, 64, 1'b1, 1'b1, lat, ce_cnt, sv1, se1, sv0, se0);
    check("align_ferr", {sv1, se1}, 2'b01);
    check("align_cnt_lit", c1, 7'd63);

    // Reset in the middle of a frame.
    set_en(1'b0);
    tick(4);
    for (int i = 0; i < 20; i++) begin
      set_sclk(1'b0); sin = 1'b1; tick(4);
      set_sclk(1'b1); tick(4);
    end
    rst = 1'b1;
    set_en(1'b1);
    @(negedge clk);
    check("midrst_zero_lit", {pd1, pd0} == '0 && {v1, e1, b1, c1} == '0, 1'b1);
    tick(2);
    rst = 1'b0;
    tick(4);
    frame(64'h01234567_89ABCDEF, 64, 1'b1, 1'b0, lat, ce_cnt, sv1, se1, sv0, se0);
    check("after_rst_valid", {sv1, se1}, 2'b10);
    check("after_rst_pdata_lit", pd1, 64'h01234567_89ABCDEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
